// File: rtl/spike_rate_monitor.sv
// Per-channel rising-edge spike counter over a programmable window of enabled cycles,
// with registered channel-select readout. Define SPIKE_MON_PEAK_EN to also track peak vmem.
module spike_rate_monitor #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16,
    parameter int V_W   = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en,
    input  logic [N_CH-1:0]                            spike_in,
    input  logic [N_CH*V_W-1:0]                        vmem_in,
    input  logic [WIN_W-1:0]                           win_len,
    input  logic                                       start,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rd_sel,
    output logic [CNT_W-1:0]                           rd_count,
    output logic [V_W-1:0]                             rd_vpeak,
    output logic                                       busy,
    output logic                                       done,
    output logic [N_CH-1:0]                            overflow
);

    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int N_SLOT = 2 ** SEL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIN_W-1:0]  timer_reg, timer_next;
    logic              done_reg, done_next;
    logic [N_CH-1:0]   prev_reg;
    logic [N_CH-1:0]   spike_event;
    logic              clear;
    logic              count_en;
    logic [CNT_W-1:0]  rd_count_reg;

    logic [CNT_W-1:0]  cnt_all [N_CH];
    logic [CNT_W-1:0]  cnt_ext [N_SLOT];

    assign spike_event = spike_in & ~prev_reg;
    assign clear       = start && (state_reg != COUNT);
    assign count_en    = (state_reg == COUNT) && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            done_reg  <= 1'b0;
            prev_reg  <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            done_reg  <= done_next;
            prev_reg  <= spike_in;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        done_next  = 1'b0;
        case (state_reg)
            COUNT: begin
                // Starts are ignored mid-window; only enabled cycles consume the window.
                if (en) begin
                    timer_next = timer_reg - WIN_W'(1);
                    if (timer_reg == WIN_W'(1)) begin
                        state_next = HOLD;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    if (win_len != '0) begin
                        state_next = COUNT;
                        timer_next = win_len;
                    end else begin
                        state_next = HOLD;
                        timer_next = '0;
                        done_next  = 1'b1;
                    end
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] cnt_reg;
        logic             ovf_reg;

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                cnt_reg <= '0;
                ovf_reg <= 1'b0;
            end else if (count_en && spike_event[gi]) begin
                // A saturated counter holds and records the lost event.
                if (cnt_reg == {CNT_W{1'b1}}) begin
                    ovf_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end

        assign cnt_all[gi]  = cnt_reg;
        assign overflow[gi] = ovf_reg;
    end

    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_cnt_slot
        if (gi < N_CH) begin : g_real
            assign cnt_ext[gi] = cnt_all[gi];
        end else begin : g_empty
            assign cnt_ext[gi] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_reg <= '0;
        end else begin
            rd_count_reg <= cnt_ext[rd_sel];
        end
    end

`ifdef SPIKE_MON_PEAK_EN
    logic [V_W-1:0] peak_all [N_CH];
    logic [V_W-1:0] peak_ext [N_SLOT];
    logic [V_W-1:0] rd_vpeak_reg;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_peak
        logic [V_W-1:0] peak_reg;

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                peak_reg <= '0;
            end else if (count_en && (vmem_in[gi*V_W +: V_W] > peak_reg)) begin
                peak_reg <= vmem_in[gi*V_W +: V_W];
            end
        end

        assign peak_all[gi] = peak_reg;
    end

    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_peak_slot
        if (gi < N_CH) begin : g_real
            assign peak_ext[gi] = peak_all[gi];
        end else begin : g_empty
            assign peak_ext[gi] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vpeak_reg <= '0;
        end else begin
            rd_vpeak_reg <= peak_ext[rd_sel];
        end
    end

    assign rd_vpeak = rd_vpeak_reg;
`else
    logic unused_vmem;
    assign unused_vmem = ^vmem_in;
    assign rd_vpeak    = '0;
`endif

    assign rd_count = rd_count_reg;
    assign busy     = (state_reg == COUNT);
    assign done     = done_reg;

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Scoreboard bench for spike_rate_monitor: expected readouts are queued as stimulus is
// planned and popped when the corresponding channel readout arrives.
module tb_spike_rate_monitor;

    localparam int N_CH  = 2;
    localparam int CNT_W = 4;
    localparam int WIN_W = 16;
    localparam int V_W   = 8;
    localparam int SEL_W = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [N_CH-1:0]    spike_in;
    logic [N_CH*V_W-1:0] vmem_in;
    logic [WIN_W-1:0]   win_len;
    logic               start;
    logic [SEL_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   rd_count;
    logic [V_W-1:0]     rd_vpeak;
    logic               busy;
    logic               done;
    logic [N_CH-1:0]    overflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string name;
        int    ch;
        int    cnt;
        int    vp;
    } exp_t;

    exp_t exp_q[$];

    spike_rate_monitor #(
        .N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .V_W(V_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in), .vmem_in(vmem_in),
        .win_len(win_len), .start(start), .rd_sel(rd_sel), .rd_count(rd_count),
        .rd_vpeak(rd_vpeak), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic open_window(input int len);
        start   = 1'b1;
        win_len = WIN_W'(len);
        step();
        start   = 1'b0;
    endtask

    task automatic read_ch(input int ch, output int cnt, output int vp);
        rd_sel = SEL_W'(ch);
        step();
        cnt = int'(rd_count);
        vp  = int'(rd_vpeak);
    endtask

    function automatic int peak_exp(input int v);
`ifdef SPIKE_MON_PEAK_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic test_reset();
        int c, v;
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            spike_in = ~spike_in;
            step();
        end
        rst = 1'b0;
        spike_in = '0;
        n_cmp++; if (rd_count !== '0) begin n_bad++; $display("FAIL reset_rd_count got %0d want 0", rd_count); end
        n_cmp++; if (rd_vpeak !== '0) begin n_bad++; $display("FAIL reset_rd_vpeak got %0d want 0", rd_vpeak); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (overflow !== 2'b00) begin n_bad++; $display("FAIL reset_overflow got %b want 00", overflow); end
        exp_q.push_back('{"reset_ch0", 0, 0, 0});
        exp_q.push_back('{"reset_ch1", 1, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
            n_cmp++; if (v !== e.vp) begin n_bad++; $display("FAIL %s vpeak got %0d want %0d", e.name, v, e.vp); end
        end
        $display("test_reset: outputs checked after 3 reset cycles");
    endtask

    task automatic test_basic_count();
        int c, v, got;
        exp_t e;
        got = -1;
        open_window(100);
        for (int i = 0; i < 300; i++) begin
            spike_in = {(i % 10 == 8) && (i < 30), (i % 10 == 5) && (i < 50)};
            start    = (i == 50);
            if (i == 50) win_len = 16'd5;
            step();
            start = 1'b0;
            if (i == 49) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_mid got %b want 1", busy); end
            end
            if (done) begin got = i + 1; break; end
        end
        spike_in = '0;
        n_cmp++; if (got != 100) begin n_bad++; $display("FAIL basic_done_latency got %0d want 100", got); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse_width got %b want 0", done); end
        exp_q.push_back('{"basic_ch0", 0, 5, 0});
        exp_q.push_back('{"basic_ch1", 1, 3, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
            n_cmp++; if (v !== e.vp) begin n_bad++; $display("FAIL %s vpeak got %0d want %0d", e.name, v, e.vp); end
        end
        $display("test_basic_count: done after %0d enabled cycles", got);
    endtask

    task automatic test_edges();
        int c, v, got;
        exp_t e;
        got = -1;
        spike_in = 2'b01;
        step();
        step();
        open_window(50);
        for (int i = 0; i < 200; i++) begin
            spike_in = {(i == 49), 1'b1};
            step();
            if (done) begin got = i + 1; break; end
        end
        n_cmp++; if (got != 50) begin n_bad++; $display("FAIL edges_done_latency got %0d want 50", got); end
        spike_in = 2'b00;
        step();
        spike_in = 2'b11;
        step();
        spike_in = 2'b00;
        exp_q.push_back('{"edges_ch0_held", 0, 0, 0});
        exp_q.push_back('{"edges_ch1_last", 1, 1, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
        end
        $display("test_edges: held level, final-cycle and post-done pulses");
    endtask

    task automatic test_pause();
        int c, v, got;
        exp_t e;
        got = -1;
        open_window(100);
        for (int i = 0; i < 300; i++) begin
            en = !((i >= 30) && (i < 50));
            spike_in = {(i == 35),
                        (i == 10) || (i == 20) || (i == 32) || (i == 37) ||
                        (i == 42) || (i == 47) || (i == 60)};
            step();
            if (done) begin got = i + 1; break; end
        end
        en = 1'b1;
        spike_in = '0;
        n_cmp++; if (got != 120) begin n_bad++; $display("FAIL pause_done_latency got %0d want 120", got); end
        exp_q.push_back('{"pause_ch0", 0, 3, 0});
        exp_q.push_back('{"pause_ch1", 1, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
        end
        $display("test_pause: done after %0d cycles with 20 paused", got);
    endtask

    task automatic test_saturation();
        int c, v, got;
        exp_t e;
        got = -1;
        open_window(100);
        for (int i = 0; i < 300; i++) begin
            spike_in = {1'b0, (i % 4 == 2) && (i < 80)};
            step();
            if (done) begin got = i + 1; break; end
        end
        spike_in = '0;
        n_cmp++; if (got != 100) begin n_bad++; $display("FAIL sat_done_latency got %0d want 100", got); end
        n_cmp++; if (overflow !== 2'b01) begin n_bad++; $display("FAIL sat_overflow got %b want 01", overflow); end
        exp_q.push_back('{"sat_ch0", 0, 15, 0});
        exp_q.push_back('{"sat_ch1", 1, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
        end
        n_cmp++; if (overflow !== 2'b01) begin n_bad++; $display("FAIL sat_overflow_sticky got %b want 01", overflow); end
        open_window(10);
        n_cmp++; if (overflow !== 2'b00) begin n_bad++; $display("FAIL sat_overflow_cleared got %b want 00", overflow); end
        exp_q.push_back('{"sat_live_ch0", 0, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
        end
        for (int i = 0; i < 50 && !done; i++) step();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sat_second_done got %b want 1", done); end
        $display("test_saturation: ch0 saturated, cleared by next start");
    endtask

    task automatic test_peak();
        int c, v, got;
        exp_t e;
        got = -1;
        vmem_in = {8'd250, 8'd0};
        open_window(20);
        for (int i = 0; i < 100; i++) begin
            vmem_in[7:0]  = 8'd7;
            vmem_in[15:8] = (i == 3) ? 8'd10 : (i == 4) ? 8'd200 : (i == 5) ? 8'd90 : 8'd0;
            spike_in = {1'b0, (i == 8)};
            step();
            if (done) begin got = i + 1; break; end
        end
        spike_in = '0;
        vmem_in  = {8'd255, 8'd255};
        step();
        vmem_in  = '0;
        n_cmp++; if (got != 20) begin n_bad++; $display("FAIL peak_done_latency got %0d want 20", got); end
        exp_q.push_back('{"peak_ch0", 0, 1, peak_exp(7)});
        exp_q.push_back('{"peak_ch1", 1, 0, peak_exp(200)});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
            n_cmp++; if (v !== e.vp) begin n_bad++; $display("FAIL %s vpeak got %0d want %0d", e.name, v, e.vp); end
        end
        open_window(0);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_win_done got %b want 1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_win_busy got %b want 0", busy); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_win_done_width got %b want 0", done); end
        exp_q.push_back('{"zero_ch0", 0, 0, 0});
        exp_q.push_back('{"zero_ch1", 1, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
            n_cmp++; if (v !== e.vp) begin n_bad++; $display("FAIL %s vpeak got %0d want %0d", e.name, v, e.vp); end
        end
        $display("test_peak: peak tracking and zero-length window");
    endtask

    task automatic test_reset_mid_window();
        int c, v, seen;
        exp_t e;
        seen = 0;
        open_window(40);
        for (int i = 0; i < 10; i++) begin
            spike_in = {1'b0, (i == 2) || (i == 6)};
            step();
        end
        spike_in = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (rd_count !== '0) begin n_bad++; $display("FAIL midrst_rd_count got %0d want 0", rd_count); end
        for (int i = 0; i < 60; i++) begin
            step();
            if (done) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_no_done got %0d pulses want 0", seen); end
        exp_q.push_back('{"midrst_ch0", 0, 0, 0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            read_ch(e.ch, c, v);
            n_cmp++; if (c !== e.cnt) begin n_bad++; $display("FAIL %s count got %0d want %0d", e.name, c, e.cnt); end
        end
        $display("test_reset_mid_window: window aborted without done");
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        spike_in = '0;
        vmem_in  = '0;
        win_len  = '0;
        start    = 1'b0;
        rd_sel   = '0;
        test_reset();
        test_basic_count();
        test_edges();
        test_pause();
        test_saturation();
        test_peak();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
